// File: rtl/hci_core_fifo_if.sv
// HCI core channel: request (master -> slave) and response (slave -> master) signals.
interface hci_core_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0] data;
  logic [1:0]    boffs;
  logic          lrdy;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_opc;

  modport master (
    output req, add, wen, be, data, boffs, lrdy,
    input  gnt, r_data, r_valid, r_opc
  );

  modport slave (
    input  req, add, wen, be, data, boffs, lrdy,
    output gnt, r_data, r_valid, r_opc
  );
endinterface

// File: rtl/hci_core_fifo.sv
// Request-side FIFO between an HCI core initiator and the interconnect.
// Registered (no fall-through); responses and lrdy pass straight through.
module hci_core_fifo #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  hci_core_intf.slave                   tcdm_slave,
  hci_core_intf.master                  tcdm_master,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   data;
    logic [1:0]      boffs;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  entry_t        head;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign count_o = count_q;

  assign tcdm_slave.gnt = ~full_o;
  assign push = tcdm_slave.req & ~full_o;
  assign pop  = ~empty_o & tcdm_master.gnt;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is unreset: it is only observed while req is high.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      mem_q[wr_ptr_q] <= '{add:   tcdm_slave.add,
                           wen:   tcdm_slave.wen,
                           be:    tcdm_slave.be,
                           data:  tcdm_slave.data,
                           boffs: tcdm_slave.boffs};
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign tcdm_master.req   = ~empty_o;
  assign tcdm_master.add   = head.add;
  assign tcdm_master.wen   = head.wen;
  assign tcdm_master.be    = head.be;
  assign tcdm_master.data  = head.data;
  assign tcdm_master.boffs = head.boffs;
  assign tcdm_master.lrdy  = tcdm_slave.lrdy;

  assign tcdm_slave.r_data  = tcdm_master.r_data;
  assign tcdm_slave.r_valid = tcdm_master.r_valid;
  assign tcdm_slave.r_opc   = tcdm_master.r_opc;

endmodule
